fetch_line_buffer: RTL and testbench

FETCH_LINE_BUFFER -- requirements
Module: fetch_line_buffer

---
 rtl/fetch_line_buffer.sv | 127 ++++++++++++
 tb/tb_fetch_line_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: one-line instruction fetch buffer with critical-word-first
// wrapping line fill, early restart and same-cycle bypass of acknowledged data.
`default_nettype none

module fetch_line_buffer #(
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_addr,
  output logic [31:0] instruction,
  output logic        inst_ready,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int             IDX_W    = $clog2(LINE_WORDS);
  localparam int             TAG_W    = 30 - IDX_W;
  localparam logic [IDX_W:0] LAST_ACK = (IDX_W + 1)'(LINE_WORDS - 1);
  localparam logic [0:0]     IDLE     = 1'b0;
  localparam logic [0:0]     FILL     = 1'b1;

  logic [0:0]            state, state_next;
  logic [TAG_W-1:0]      tag;
  logic [LINE_WORDS-1:0] valid;
  logic [31:0]           data [LINE_WORDS];
  logic [IDX_W:0]        ack_cnt;
  logic                  discard;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx, ack_idx, next_idx;
  logic             tag_match, hit_valid, hit_bypass, hit;
  logic             ack_fire, ack_keep, last_ack, start_fill;
  logic [31:0]      hit_word;
  logic             unused_addr_bits;

  assign req_tag          = inst_addr[31:IDX_W+2];
  assign req_idx          = inst_addr[IDX_W+1:2];
  assign ack_idx          = mem_addr[IDX_W+1:2];
  assign next_idx         = ack_idx + 1'b1;
  assign unused_addr_bits = ^inst_addr[1:0];

  assign tag_match  = (req_tag == tag);
  assign hit_valid  = tag_match && valid[req_idx];
  assign ack_fire   = (state == FILL) && mem_ack;
  // Data of a request that was outstanding when inv arrived is dropped.
  assign ack_keep   = ack_fire && !discard && !inv;
  assign hit_bypass = ack_keep && (mem_addr[31:2] == inst_addr[31:2]);
  assign hit        = !inv && (hit_valid || hit_bypass);
  assign hit_word   = hit_bypass ? mem_rdata : data[req_idx];
  assign last_ack   = (ack_cnt == LAST_ACK);
  // New fill: miss while idle, or the core left the line mid-fill at an ack.
  assign start_fill = ((state == IDLE) && !hit_valid) ||
                      (ack_fire && !last_ack && !tag_match);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_fill) state_next = FILL;
      FILL:    if (ack_fire && last_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == FILL);
  end

  always_ff @(posedge clk) begin
    if (ack_keep) begin
      data[ack_idx] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid       <= '0;
      tag         <= '0;
      mem_addr    <= '0;
      ack_cnt     <= '0;
      discard     <= 1'b0;
      inst_ready  <= 1'b0;
      instruction <= NOP_WORD;
    end else begin
      inst_ready  <= hit;
      instruction <= hit ? hit_word : NOP_WORD;

      if (ack_fire) begin
        discard <= 1'b0;
      end else if (inv && (state == FILL)) begin
        discard <= 1'b1;
      end

      if (start_fill) begin
        valid    <= '0;
        tag      <= req_tag;
        mem_addr <= {inst_addr[31:2], 2'b00};
        ack_cnt  <= '0;
      end else begin
        if (inv) begin
          valid <= '0;
        end else if (ack_keep) begin
          valid[ack_idx] <= 1'b1;
        end
        if (ack_fire) begin
          ack_cnt  <= ack_cnt + 1'b1;
          mem_addr <= {tag, next_idx, 2'b00};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_line_buffer.sv
// Testbench for fetch_line_buffer: directed vector table, hand-written corner
// sequences and a randomized run against a line-level reference model.
`default_nettype none

module tb_fetch_line_buffer;

  localparam int          LW   = 4;
  localparam int          LB   = LW * 4;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n, inv, mem_ack, inst_ready, mem_req;
  logic [31:0] inst_addr, instruction, mem_addr, mem_rdata;

  int checks = 0;
  int errors = 0;

  fetch_line_buffer #(.LINE_WORDS(LW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .inst_addr(inst_addr), .instruction(instruction),
    .inst_ready(inst_ready), .inv(inv), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffered line as a base address plus per-word flags,
  // and the fill as a pointer with a count of words still to arrive.
  logic [31:0] m_base, m_ptr;
  int          m_left;
  bit          m_fill, m_drop;
  bit          m_valid [LW];
  logic [31:0] m_data  [LW];
  logic        m_ready, m_req;
  logic [31:0] m_instr, m_addr;

  task automatic model_step(input logic r, input logic v, input logic [31:0] a_in,
                            input logic k, input logic [31:0] rd);
    logic [31:0] a, base;
    int          w;
    bit          same, got, keep, byp, hitv, restart;
    if (!r) begin
      m_fill = 0; m_drop = 0; m_base = 0; m_ptr = 0; m_left = 0;
      for (int i = 0; i < LW; i++) m_valid[i] = 0;
      m_ready = 0; m_instr = NOP; m_req = 0; m_addr = 0;
    end else begin
      a       = a_in & ~32'h3;
      base    = a & ~32'(LB - 1);
      w       = int'((a % LB) / 4);
      same    = (base == m_base);
      got     = m_fill && k;
      keep    = got && !m_drop && !v;
      byp     = keep && (m_ptr == a);
      hitv    = same && m_valid[w];
      m_ready = !v && (byp || hitv);
      m_instr = !m_ready ? NOP : (byp ? rd : m_data[w]);
      restart = (!m_fill && !hitv) || (got && m_left > 1 && !same);
      if (keep) begin
        m_data[int'((m_ptr % LB) / 4)]  = rd;
        m_valid[int'((m_ptr % LB) / 4)] = 1;
      end
      if (v) for (int i = 0; i < LW; i++) m_valid[i] = 0;
      if (got) m_drop = 0;
      else if (v && m_fill) m_drop = 1;
      if (got) begin
        m_left--;
        m_ptr = (m_ptr & ~32'(LB - 1)) | ((m_ptr + 32'd4) & 32'(LB - 1));
        if (m_left == 0) m_fill = 0;
      end
      if (restart) begin
        for (int i = 0; i < LW; i++) m_valid[i] = 0;
        m_base = base; m_ptr = a; m_left = LW; m_fill = 1;
      end
      m_req  = m_fill;
      m_addr = m_ptr;
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, sample at negedge.
  task automatic cycle(input logic r, input logic v, input logic [31:0] a,
                       input logic k, input bit use_model);
    rst_n     = r;
    inv       = v;
    inst_addr = a;
    mem_ack   = k && m_req;
    mem_rdata = mem_word(m_addr);
    model_step(r, v, a, mem_ack, mem_rdata);
    @(negedge clk);
    if (use_model) begin
      check("model inst_ready", {31'b0, inst_ready}, {31'b0, m_ready});
      check("model instruction", instruction, m_instr);
      check("model mem_req", {31'b0, mem_req}, {31'b0, m_req});
      if (m_req || !r) check("model mem_addr", mem_addr, m_addr);
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic        r;
    logic        v;
    logic [31:0] a;
    logic        k;
    logic        req;
    logic [31:0] maddr;
    logic        rdy;
    logic [31:0] iaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [31:0] a, input logic k,
                     input logic req, input logic [31:0] maddr, input logic rdy,
                     input logic [31:0] iaddr);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.k = k;
    t.req = req; t.maddr = maddr; t.rdy = rdy; t.iaddr = iaddr;
    vecs.push_back(t);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] exp_i;
    int          roll;
    rst_n = 1'b0; inv = 1'b0; mem_ack = 1'b0; inst_addr = '0; mem_rdata = '0;
    m_req = 1'b0; m_addr = '0;

    // Cold miss at 0x100, then critical-word-first wrapped fill at 0x208.
    add(0, 0, 32'h100, 0, 0, 32'h000, 0, NONE);
    add(1, 0, 32'h100, 0, 1, 32'h100, 0, NONE);
    add(1, 0, 32'h100, 0, 1, 32'h100, 0, NONE);
    add(1, 0, 32'h100, 1, 1, 32'h104, 1, 32'h100);
    add(1, 0, 32'h100, 0, 1, 32'h104, 1, 32'h100);
    add(1, 0, 32'h100, 1, 1, 32'h108, 1, 32'h100);
    add(1, 0, 32'h100, 0, 1, 32'h108, 1, 32'h100);
    add(1, 0, 32'h100, 1, 1, 32'h10C, 1, 32'h100);
    add(1, 0, 32'h100, 0, 1, 32'h10C, 1, 32'h100);
    add(1, 0, 32'h100, 1, 0, 32'h000, 1, 32'h100);
    add(1, 0, 32'h10C, 0, 0, 32'h000, 1, 32'h10C);
    add(1, 0, 32'h104, 0, 0, 32'h000, 1, 32'h104);
    add(1, 0, 32'h208, 0, 1, 32'h208, 0, NONE);
    add(1, 0, 32'h208, 1, 1, 32'h20C, 1, 32'h208);
    add(1, 0, 32'h208, 1, 1, 32'h200, 1, 32'h208);
    add(1, 0, 32'h208, 1, 1, 32'h204, 1, 32'h208);
    add(1, 0, 32'h208, 1, 0, 32'h000, 1, 32'h208);
    add(1, 0, 32'h200, 0, 0, 32'h000, 1, 32'h200);
    add(1, 0, 32'h204, 0, 0, 32'h000, 1, 32'h204);
    add(1, 0, 32'h208, 0, 0, 32'h000, 1, 32'h208);
    add(1, 0, 32'h20C, 0, 0, 32'h000, 1, 32'h20C);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].a, vecs[i].k, 1'b0);
      exp_i = (vecs[i].iaddr == NONE) ? NOP : mem_word(vecs[i].iaddr);
      check($sformatf("vec%0d inst_ready", i), {31'b0, inst_ready}, {31'b0, vecs[i].rdy});
      check($sformatf("vec%0d instruction", i), instruction, exp_i);
      check($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].req});
      if (vecs[i].req || !vecs[i].r)
        check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].maddr);
    end

    // Early restart: each word returned right after its ack, gaps not ready.
    do_reset();
    cycle(1, 0, 32'h300, 0, 1);
    cycle(1, 0, 32'h300, 0, 1);
    cycle(1, 0, 32'h300, 1, 1);
    check("restart word0 ready", {31'b0, inst_ready}, 32'd1);
    check("restart word0 data", instruction, mem_word(32'h300));
    cycle(1, 0, 32'h304, 0, 1);
    check("restart gap ready", {31'b0, inst_ready}, 32'd0);
    cycle(1, 0, 32'h304, 1, 1);
    check("restart word1 data", instruction, mem_word(32'h304));
    cycle(1, 0, 32'h308, 1, 1);
    cycle(1, 0, 32'h308, 1, 1);

    // Abandon: jump to 0x800 before the second ack of line 0x400.
    do_reset();
    cycle(1, 0, 32'h400, 0, 1);
    cycle(1, 0, 32'h400, 1, 1);
    cycle(1, 0, 32'h800, 0, 1);
    check("abandon addr stable", mem_addr, 32'h404);
    cycle(1, 0, 32'h800, 1, 1);
    check("abandon new req", {31'b0, mem_req}, 32'd1);
    check("abandon new addr", mem_addr, 32'h800);
    for (int i = 0; i < LW; i++) cycle(1, 0, 32'h800, 1, 1);
    cycle(1, 0, 32'h800, 0, 1);
    cycle(1, 0, 32'h400, 0, 1);
    check("abandon lost ready", {31'b0, inst_ready}, 32'd0);
    check("abandon refetch addr", mem_addr, 32'h400);

    // Invalidate coinciding with the ack of 0x504.
    do_reset();
    cycle(1, 0, 32'h504, 0, 1);
    cycle(1, 1, 32'h504, 1, 1);
    check("inv ack ready", {31'b0, inst_ready}, 32'd0);
    for (int i = 0; i < LW - 1; i++) cycle(1, 0, 32'h504, 1, 1);
    check("inv fill done req", {31'b0, mem_req}, 32'd0);
    cycle(1, 0, 32'h504, 0, 1);
    check("inv refetch req", {31'b0, mem_req}, 32'd1);
    check("inv refetch addr", mem_addr, 32'h504);

    // Reset in the middle of a fill with a same-edge ack.
    do_reset();
    cycle(1, 0, 32'h600, 0, 1);
    cycle(0, 0, 32'h600, 1, 1);
    check("midreset req", {31'b0, mem_req}, 32'd0);
    check("midreset ready", {31'b0, inst_ready}, 32'd0);
    check("midreset instruction", instruction, 32'h0000_0013);
    cycle(1, 0, 32'h600, 0, 1);
    check("midreset refetch addr", mem_addr, 32'h600);

    // Randomized program-counter walk against the model.
    do_reset();
    pc = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      roll = int'($urandom_range(99));
      if (roll < 55) pc = pc + 32'd4;
      else if (roll >= 75) pc = 32'h1000 + (32'($urandom_range(63)) << 2);
      if (pc >= 32'h1100) pc = 32'h1000;
      cycle(($urandom_range(199) != 0), ($urandom_range(99) < 3),
            pc | 32'($urandom_range(3)), 1'($urandom_range(1)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
